// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4-to-1 mux: steps the selects, samples y per channel, emits 4-bit frames.
// Optional channel skip mask enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             s0,
  output logic             s1,
  input  logic             y,
`ifdef MUX_SCAN_MASK_EN
  input  logic [3:0]       mask,
`endif
  output logic [3:0]       frame_data,
  output logic [SEQ_W-1:0] frame_seq,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CH_W  = 2;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t             r_state, w_nxt_state;
  logic [CH_W-1:0]    r_chan, w_nxt_chan;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [3:0]         r_shift, w_nxt_shift;
  logic [3:0]         r_mask, w_nxt_mask;
  logic [3:0]         w_mask_in;
  logic [3:0]         w_frame;
  logic               w_done;
  logic               w_first_ok, w_next_ok;
  logic [CH_W-1:0]    w_first_idx, w_next_idx;
  logic [3:0]         r_fdata;
  logic [SEQ_W-1:0]   r_fseq, r_seq_cnt;
  logic               r_valid, r_ovf, r_busy;

`ifdef MUX_SCAN_MASK_EN
  assign w_mask_in = mask;
`else
  assign w_mask_in = 4'h0;
`endif

  // Lowest unmasked channel for a frame start.
  always_comb begin
    w_first_ok  = 1'b0;
    w_first_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!w_mask_in[i]) begin
        w_first_ok  = 1'b1;
        w_first_idx = CH_W'(i);
      end
    end
  end

  // Next unmasked channel above the current one within this frame.
  always_comb begin
    w_next_ok  = 1'b0;
    w_next_idx = '0;
    for (int i = 3; i >= 1; i--) begin
      if (i > int'(r_chan) && !r_mask[i]) begin
        w_next_ok  = 1'b1;
        w_next_idx = CH_W'(i);
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_chan  = r_chan;
    w_nxt_cnt   = r_cnt;
    w_nxt_shift = r_shift;
    w_nxt_mask  = r_mask;
    w_frame     = r_shift;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt_chan = '0;
        w_nxt_cnt  = '0;
        if (en && w_first_ok) begin
          w_nxt_state = ST_SCAN;
          w_nxt_chan  = w_first_idx;
          w_nxt_mask  = w_mask_in;
          w_nxt_shift = 4'h0;
        end
      end
      ST_SCAN: begin
        if (r_cnt == CNT_W'(DWELL - 1)) begin
          w_frame[r_chan] = y;
          w_nxt_cnt       = '0;
          if (w_next_ok) begin
            w_nxt_chan  = w_next_idx;
            w_nxt_shift = w_frame;
          end else begin
            // Last active channel sampled: frame completes, restart or go idle.
            w_done = 1'b1;
            if (en && w_first_ok) begin
              w_nxt_chan  = w_first_idx;
              w_nxt_mask  = w_mask_in;
              w_nxt_shift = 4'h0;
            end else begin
              w_nxt_state = ST_IDLE;
              w_nxt_chan  = '0;
              w_nxt_shift = 4'h0;
            end
          end
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_chan    <= '0;
      r_cnt     <= '0;
      r_shift   <= 4'h0;
      r_mask    <= 4'h0;
      r_busy    <= 1'b0;
      r_fdata   <= 4'h0;
      r_fseq    <= '0;
      r_seq_cnt <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_chan  <= w_nxt_chan;
      r_cnt   <= w_nxt_cnt;
      r_shift <= w_nxt_shift;
      r_mask  <= w_nxt_mask;
      r_busy  <= (w_nxt_state == ST_SCAN);
      // Output register: load on free slot or same-edge accept, otherwise drop.
      if (w_done) begin
        r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
        if (!r_valid || frame_ready) begin
          r_fdata <= w_frame;
          r_fseq  <= r_seq_cnt;
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign s0          = r_chan[1];
  assign s1          = r_chan[0];
  assign busy        = r_busy;
  assign frame_data  = r_fdata;
  assign frame_seq   = r_fseq;
  assign frame_valid = r_valid;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with a behavioural 4-to-1 mux; mask test under MUX_SCAN_MASK_EN.
module tb_mux_scan_ctrl;
  localparam int unsigned DWELL = 4;
  localparam int unsigned SEQ_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, s0, s1, y;
  logic [3:0]       in_vec;
  logic [3:0]       mask;
  logic [3:0]       frame_data;
  logic [SEQ_W-1:0] frame_seq;
  logic             frame_valid, frame_ready, overflow, busy;

  int total = 0;
  int bad   = 0;
  logic [SEQ_W+3:0] exp_q[$];
  int unsigned exp_seq = 0;

  always #5 clk = ~clk;
  assign y = in_vec[{s0, s1}];

  mux_scan_ctrl #(.DWELL(DWELL), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .en(en), .s0(s0), .s1(s1), .y(y),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask),
`endif
    .frame_data(frame_data), .frame_seq(frame_seq), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .overflow(overflow), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    exp_q.push_back({SEQ_W'(exp_seq), d});
    exp_seq++;
  endtask

  // Monitor: every accepted frame must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'({frame_seq, frame_data}), 32'hFFFF_FFFF);
      end else begin
        chk("frame", 32'({frame_seq, frame_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; in_vec = 4'h0; mask = 4'h0; frame_ready = 1'b1;
    tick(2);
    chk("rst_sel", 32'({s0, s1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_data", 32'(frame_data), 32'd0);
    chk("rst_seq", 32'(frame_seq), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // 1: reset mid-scan at cycle 6, en held restarts at channel 0
    en = 1'b1; in_vec = 4'b0110;
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sel", 32'({s0, s1}), 32'd0);
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    tick(1);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_sel", 32'({s0, s1}), 32'd0);
    en = 1'b0;
    push(4'b0110);
    tick(20);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: basic frame, select stepping and latency
    in_vec = 4'b1101; en = 1'b1;
    tick(1);
    en = 1'b0;
    push(4'b1101);
    for (int c = 0; c < 16; c++) begin
      chk("sel_step", 32'({s0, s1}), 32'(c / 4));
      tick(1);
    end
    chk("t2_valid_rise", 32'(frame_valid), 32'd1);
    chk("t2_data", 32'(frame_data), 32'b1101);
    tick(1);
    chk("t2_valid_fall", 32'(frame_valid), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // 3: back-to-back frames, no bubble between scans
    en = 1'b1;
    tick(1);
    for (int f = 0; f < 4; f++) begin
      in_vec = 4'(4'b0101 ^ (f * 3));
      push(in_vec);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_sel", 32'({s0, s1}), 32'd0);
      if (f == 3) en = 1'b0;
      tick(16);
    end
    chk("b2b_end_idle", 32'(busy), 32'd0);
    tick(2);
    chk("b2b_ovf", 32'(overflow), 32'd0);

    // 4: backpressure, dropped frame, sequence gap
    frame_ready = 1'b0; en = 1'b1;
    tick(1);
    in_vec = 4'b0011;
    push(4'b0011);
    tick(16);
    chk("bp_valid", 32'(frame_valid), 32'd1);
    in_vec = 4'b0110;
    exp_seq++;
    tick(16);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_hold_data", 32'(frame_data), 32'b0011);
    chk("bp_hold_seq", 32'(frame_seq), 32'(SEQ_W'(exp_seq - 2)));
    in_vec = 4'b1001;
    push(4'b1001);
    en = 1'b0;
    tick(8);
    frame_ready = 1'b1;
    tick(10);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_seq = 0;
    chk("rst_ovf_clear", 32'(overflow), 32'd0);

    // 5: accept and load on the same edge
    frame_ready = 1'b0; en = 1'b1;
    tick(1);
    in_vec = 4'b1010;
    push(4'b1010);
    tick(16);
    in_vec = 4'b0111;
    push(4'b0111);
    en = 1'b0;
    chk("sim_valid_a", 32'(frame_valid), 32'd1);
    tick(15);
    frame_ready = 1'b1;
    tick(1);
    chk("sim_valid_b", 32'(frame_valid), 32'd1);
    chk("sim_data_b", 32'(frame_data), 32'b0111);
    chk("sim_seq_b", 32'(frame_seq), 32'd1);
    chk("sim_ovf", 32'(overflow), 32'd0);
    tick(4);

`ifdef MUX_SCAN_MASK_EN
    // 6: channel mask 0101 scans channels 1 and 3 only; all-masked never starts
    in_vec = 4'hF; mask = 4'b0101; en = 1'b1;
    tick(1);
    en = 1'b0;
    push(4'b1010);
    chk("mask_sel1", 32'({s0, s1}), 32'd1);
    tick(4);
    chk("mask_sel3", 32'({s0, s1}), 32'd3);
    tick(4);
    chk("mask_valid", 32'(frame_valid), 32'd1);
    tick(2);
    mask = 4'hF; en = 1'b1;
    tick(10);
    chk("maskF_busy", 32'(busy), 32'd0);
    chk("maskF_valid", 32'(frame_valid), 32'd0);
    en = 1'b0; mask = 4'h0;
    tick(2);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Scan sequencer that sits directly upstream of the 4-to-1 multiplexer. It drives the mux select lines `s0`/`s1`, dwells on each channel, samples the mux output `y`, and assembles one 4-bit frame per full scan. Completed frames go to a downstream consumer through a valid/ready handshake with a sequence number, and dropped frames are flagged.

## Interface

**Parameters**
- `DWELL`, default 4: cycles spent on each channel. Legal range 2..255.
- `SEQ_W`, default 8: width of the frame sequence counter.

**Ports**
- `clk`, input, 1: sole clock. All logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: scan enable. Level-sensitive; sampled in IDLE and at frame boundaries.
- `s0`, output, 1: mux select MSB. Channel index = {s0,s1}.
- `s1`, output, 1: mux select LSB.
- `y`, input, 1: mux output, sampled by this block.
- `mask`, input, 4: channel skip mask, bit n = channel n. Present only with `MUX_SCAN_MASK_EN`.
- `frame_data`, output, 4: bit n = sample from channel n.
- `frame_seq`, output, SEQ_W: sequence number of the frame in `frame_data`.
- `frame_valid`, output, 1: frame available.
- `frame_ready`, input, 1: consumer accepts the frame.
- `overflow`, output, 1: sticky flag; a completed frame was dropped.
- `busy`, output, 1: high while in SCAN.

## Operation

**FSM states**
- **IDLE**
  - `{s0,s1}` = 00, `busy` = 0.
  - `en` = 1 at the edge → SCAN, channel 0, dwell counter = 0.
- **SCAN**
  - `busy` = 1. `{s0,s1}` = current channel, registered.
  - Dwell counter runs 0..DWELL-1.
  - On the edge where the counter = DWELL-1: `y` is written into bit[channel] of the shift/assembly register, and the block advances to the next active channel with the counter reset to 0.
- **Frame completion**
  - Occurs on the sample edge of the last active channel.
  - Assembled frame and `seq_cnt` are offered to the output register on that same edge.
  - `seq_cnt` increments on every completed frame, including dropped frames, so gaps in `frame_seq` expose drops. It wraps modulo 2^SEQ_W.
  - Next state: `en` = 1 → SCAN at channel 0 (back-to-back, no bubble); `en` = 0 → IDLE.
  - `en` falling mid-scan does not abort; the current frame completes.

**Output register**
- Loads when `!frame_valid || frame_ready` on the completion edge.
- Otherwise the new frame is dropped, the held frame is unchanged, and `overflow` is set to 1.
- Handshake: transfer occurs on an edge with `frame_valid && frame_ready`. `frame_valid` then clears unless a new frame loads on the same edge, in which case it stays 1 with new data.
- While `frame_valid` = 1 and not accepted, `frame_data` and `frame_seq` are stable.
- `overflow` clears only on `rst`.

**Reset values**
- `s0` = `s1` = 0
- `frame_data` = 0, `frame_seq` = 0, `seq_cnt` = 0
- `frame_valid` = 0, `overflow` = 0, `busy` = 0
- State = IDLE

Reset mid-scan discards the partial frame. Reset takes priority over all other events.

## Timing

- Cycle numbering: cycle 0 is the first SCAN cycle.
- Channel k is selected during cycles k·DWELL .. k·DWELL+DWELL-1.
- `y` is sampled at the end of cycle k·DWELL+DWELL-1, giving DWELL-1 cycles of mux settle.
- With all channels active, `frame_valid` rises at cycle 4·DWELL.
- From `en` sampled high in IDLE: `frame_valid` rises 4·DWELL+1 cycles later.
- Continuous throughput: one frame per 4·DWELL cycles.
- The select lines change only on dwell boundaries and are glitch-free (registered).

## Configuration

`MUX_SCAN_MASK_EN`

**Defined**
- `mask` port exists and is sampled at frame start (IDLE→SCAN and each back-to-back restart).
- Masked channels are skipped with zero dwell and report bit 0.
- Frame time is N·DWELL, where N = number of unmasked channels.
- `mask` = 4'hF at a frame start: no frame begins, state = IDLE, `busy` = 0.
- Changing `mask` mid-frame has no effect until the next frame start.

**Undefined**
- No `mask` port; all four channels are always scanned.

## Test plan

Benches use DWELL = 4 and model the 4-to-1 mux behaviourally.

1. **Reset.** Assert `rst` mid-scan (cycle 6) → next cycle: all outputs 0, state IDLE; `en` held high restarts at channel 0 one cycle after `rst` falls.
2. **Basic frame.** Inputs i0..i3 = 1,0,1,1, `en` pulsed 1 cycle, `frame_ready` = 1 → `{s0,s1}` steps 00,01,10,11 for 4 cycles each; `frame_data` = 4'b1101, `frame_seq` = 0, `frame_valid` high 17 cycles after `en`, for 1 cycle; `busy` then 0.
3. **Back-to-back.** `en` held, `frame_ready` = 1, inputs toggled each frame → frames every 16 cycles, `frame_seq` 0,1,2,3, no idle cycle between scans, `overflow` = 0.
4. **Backpressure and drop.** `frame_ready` = 0 for 40 cycles with `en` held → first frame held stable with seq 0; the second completion sets `overflow`; after `frame_ready` rises, the next accepted frame shows seq 2 (gap) and `overflow` stays 1.
5. **Simultaneous accept and load.** Assert `frame_ready` exactly on the completion edge while `frame_valid` = 1 → `frame_valid` stays 1, data and seq replaced, no overflow.
6. **Mask (`MUX_SCAN_MASK_EN`).** With `mask` = 4'b0101: only channels 1 and 3 selected, frame every 8 cycles, bits 0 and 2 = 0. With `mask` = 4'hF: `busy` stays 0 and no frame is produced.
